// File: rtl/soc_mem_arbiter.sv
// Round-robin shared-memory front end: NUM_MASTERS requesters, one memory port, one transaction in flight.
// Optional busy-timeout with error response is enabled by defining SOC_MEM_ARBITER_TIMEOUT_EN.
module soc_mem_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic                          m_err,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_ack
);

  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [GW-1:0]            r_last_grant;
  logic [GW-1:0]            r_grant;
  logic [GW-1:0]            w_winner;
  logic                     w_found;
  logic                     w_sel_we;
  logic [ADDR_W-1:0]        w_sel_addr;
  logic [DATA_W-1:0]        w_sel_wdata;
  logic [NUM_MASTERS-1:0]   w_grant_oh;
  logic                     w_timeout;
  logic                     w_done;

  logic [NUM_MASTERS-1:0]   r_m_ack;
  logic [DATA_W-1:0]        r_m_rdata;
  logic                     r_mem_req;
  logic                     r_mem_we;
  logic [ADDR_W-1:0]        r_mem_addr;
  logic [DATA_W-1:0]        r_mem_wdata;

  // Two passes give the rotating priority: first masters above last_grant, then wrap to the rest.
  // NOTE: every signal written in an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (!w_found && m_req[j] && (GW'(j) > r_last_grant)) begin
        w_found  = 1'b1;
        w_winner = GW'(j);
      end
    end
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (!w_found && m_req[j] && (GW'(j) <= r_last_grant)) begin
        w_found  = 1'b1;
        w_winner = GW'(j);
      end
    end
  end

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_grant_oh  = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (w_winner == GW'(j)) begin
        w_sel_we    = m_we[j];
        w_sel_addr  = m_addr[j*ADDR_W +: ADDR_W];
        w_sel_wdata = m_wdata[j*DATA_W +: DATA_W];
      end
      w_grant_oh[j] = (r_grant == GW'(j));
    end
  end

`ifdef SOC_MEM_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  // mem_ack in the final counted cycle takes priority over the timeout.
  assign w_timeout = (r_state == ST_BUSY) && !mem_ack && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_cnt <= '0;
      end else if ((r_state == ST_BUSY) && !mem_ack) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_err <= w_timeout;
    end
  end

  assign m_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign m_err     = 1'b0;
`endif

  assign w_done = (r_state == ST_BUSY) && (mem_ack || w_timeout);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_found) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_done)  w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Reset leaves last_grant at the top master so the first search starts at master 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= GW'(NUM_MASTERS - 1);
      r_grant      <= '0;
      r_m_ack      <= '0;
      r_m_rdata    <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_m_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant      <= w_winner;
            r_last_grant <= w_winner;
            r_mem_req    <= 1'b1;
            r_mem_we     <= w_sel_we;
            r_mem_addr   <= w_sel_addr;
            r_mem_wdata  <= w_sel_wdata;
          end
        end
        ST_BUSY: begin
          if (w_done) begin
            r_mem_req <= 1'b0;
            r_m_ack   <= w_grant_oh;
            if (mem_ack) r_m_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_ack     = r_m_ack;
  assign m_rdata   = r_m_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Scoreboard bench for soc_mem_arbiter with a behavioural memory (programmable wait states).
// Timeout scenario runs only when SOC_MEM_ARBITER_TIMEOUT_EN is defined.
module tb_soc_mem_arbiter;

  localparam int NM = 2;
  localparam int AW = 64;
  localparam int DW = 64;

  typedef struct {
    int          master;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        err;
  } sb_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [NM-1:0]    m_req;
  logic [NM-1:0]    m_we;
  logic [NM*AW-1:0] m_addr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM-1:0]    m_ack;
  logic             m_err;
  logic [DW-1:0]    m_rdata;
  logic             mem_req;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata;
  logic             mem_ack;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  sb_t         sb_q[$];
  sb_t         mon_e;
  logic [63:0] exp_last_rdata = '0;
  int          ack_cyc = 0;
  int          memack_cyc = 0;
  int          busy_cycles = 0;
  int          mem_delay = 0;
  int          wcnt = 0;
  logic        mem_off = 1'b0;
  logic        spur_req = 1'b0;

  soc_mem_arbiter #(
    .NUM_MASTERS(NM),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .TIMEOUT    (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_ack    (m_ack),
    .m_err    (m_err),
    .m_rdata  (m_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] rd_fn(input logic [63:0] a);
    if (a == 64'h1000) return 64'hDEADBEEF;
    return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
  endfunction

  task automatic push_exp(input int m, input logic we, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic err);
    sb_t e;
    if (!err) exp_last_rdata = rd_fn(addr);
    e.master = m;
    e.we     = we;
    e.addr   = addr;
    e.wdata  = wdata;
    e.rdata  = exp_last_rdata;
    e.err    = err;
    sb_q.push_back(e);
  endtask

  task automatic drive(input int m, input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    m_req[m]              = 1'b1;
    m_we[m]               = we;
    m_addr[m*AW +: AW]    = addr;
    m_wdata[m*DW +: DW]   = wdata;
  endtask

  // Memory model: answers after mem_delay extra cycles; mem_off stalls it, spur_req pulses a stray ack.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (spur_req) begin
        mem_ack   = 1'b1;
        mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        spur_req  = 1'b0;
      end else if (mem_req) begin
        busy_cycles++;
        if (!mem_off) begin
          if (wcnt == mem_delay) begin
            mem_ack    = 1'b1;
            mem_rdata  = rd_fn(mem_addr);
            memack_cyc = cyc;
            wcnt       = 0;
          end else begin
            wcnt++;
          end
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Completion monitor: every m_ack pops the scoreboard; memory-side fields checked each busy cycle.
  always @(negedge clk) begin
    if (reset && (m_ack != '0)) begin
      ack_cyc = cyc;
      check("ack_onehot", 64'($onehot(m_ack)), 64'd1);
      if (sb_q.size() == 0) begin
        check("ack_unexpected", 64'(m_ack), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("ack_master", 64'(m_ack), 64'(1) << mon_e.master);
        check("ack_rdata", m_rdata, mon_e.rdata);
        check("ack_err", 64'(m_err), 64'(mon_e.err));
      end
    end
    if (reset && mem_req && (sb_q.size() > 0)) begin
      check("mem_addr", mem_addr, sb_q[0].addr);
      check("mem_we", 64'(mem_we), 64'(sb_q[0].we));
      check("mem_wdata", mem_wdata, sb_q[0].wdata);
    end
  end

  task automatic do_txn(input int m, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic err, output int lat);
    int t0;
    int guard;
    @(negedge clk); #1;
    push_exp(m, we, addr, wdata, err);
    drive(m, we, addr, wdata);
    t0    = cyc;
    guard = 0;
    while (!m_ack[m] && guard < 100) begin
      @(negedge clk); #1;
      guard++;
    end
    check("txn_completed", 64'(m_ack[m]), 64'd1);
    lat      = cyc - t0;
    m_req[m] = 1'b0;
  endtask

  task automatic run_contention(input int n);
    int cnt[NM];
    int acks[$];
    int guard;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < NM; i++) begin
        push_exp(i, k[0], 64'h2000 + 64'(i) * 64'h100 + 64'(k) * 8, {32'(i), 32'(k)} ^ 64'h0F0F, 1'b0);
      end
    end
    @(negedge clk); #1;
    for (int i = 0; i < NM; i++) begin
      cnt[i] = 0;
      drive(i, 1'b0, 64'h2000 + 64'(i) * 64'h100, {32'(i), 32'd0} ^ 64'h0F0F);
    end
    guard = 0;
    while ((cnt[0] < n || cnt[1] < n) && guard < 200) begin
      @(negedge clk); #1;
      guard++;
      for (int i = 0; i < NM; i++) begin
        if (m_ack[i]) begin
          acks.push_back(cyc);
          cnt[i]++;
          if (cnt[i] < n) begin
            drive(i, cnt[i][0], 64'h2000 + 64'(i) * 64'h100 + 64'(cnt[i]) * 8,
                  {32'(i), 32'(cnt[i])} ^ 64'h0F0F);
          end else begin
            m_req[i] = 1'b0;
          end
        end
      end
    end
    check("contention_done", 64'(guard < 200), 64'd1);
    for (int k = 1; k < acks.size(); k++) check("ack_spacing", 64'(acks[k] - acks[k-1]), 64'd3);
  endtask

  task automatic spurious_ack;
    @(negedge clk); #1;
    spur_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("spur_rdata", m_rdata, exp_last_rdata);
    check("spur_mem_req", 64'(mem_req), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset   = 1'b0;
    m_req   = '0;
    m_we    = '0;
    m_addr  = '0;
    m_wdata = '0;
    #1;
    check("rst_m_ack", 64'(m_ack), 64'd0);
    check("rst_m_err", 64'(m_err), 64'd0);
    check("rst_m_rdata", m_rdata, 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    // Single zero-wait read by master 0.
    do_txn(0, 1'b0, 64'h1000, 64'h0, 1'b0, lat);
    check("single_latency", 64'(lat), 64'd2);
    check("single_rdata", m_rdata, 64'hDEADBEEF);

    // Reset while a write is stalled in BUSY.
    mem_off = 1'b1;
    @(negedge clk); #1;
    push_exp(0, 1'b1, 64'h3000, 64'h1234_5678, 1'b0);
    drive(0, 1'b1, 64'h3000, 64'h1234_5678);
    repeat (3) @(negedge clk);
    check("rst_busy_mem_req", 64'(mem_req), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rstb_m_ack", 64'(m_ack), 64'd0);
    check("rstb_m_rdata", m_rdata, 64'd0);
    check("rstb_mem_req", 64'(mem_req), 64'd0);
    check("rstb_mem_we", 64'(mem_we), 64'd0);
    check("rstb_mem_addr", mem_addr, 64'd0);
    check("rstb_mem_wdata", mem_wdata, 64'd0);
    sb_q.delete();
    m_req          = '0;
    m_we           = '0;
    exp_last_rdata = '0;
    mem_off        = 1'b0;
    repeat (2) @(negedge clk);
    #3 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_restart", 64'(mem_req), 64'd0);

    // Both masters contend from reset: grant order 0,1,0,1...
    mem_delay = 0;
    run_contention(4);

    // Five wait states on a write by master 1.
    mem_delay   = 5;
    busy_cycles = 0;
    do_txn(1, 1'b1, 64'h20, 64'h55, 1'b0, lat);
    check("ws_busy_cycles", 64'(busy_cycles), 64'd6);
    check("ws_ack_after_memack", 64'(ack_cyc - memack_cyc), 64'd1);
    check("ws_latency", 64'(lat), 64'd7);
    mem_delay = 0;

    // Stray mem_ack in IDLE, then a normal read still takes two cycles.
    spurious_ack();
    do_txn(0, 1'b0, 64'h40, 64'h0, 1'b0, lat);
    check("post_spur_latency", 64'(lat), 64'd2);

`ifdef SOC_MEM_ARBITER_TIMEOUT_EN
    mem_off     = 1'b1;
    busy_cycles = 0;
    do_txn(0, 1'b0, 64'h80, 64'h0, 1'b1, lat);
    check("to_busy_cycles", 64'(busy_cycles), 64'd4);
    check("to_latency", 64'(lat), 64'd5);
    mem_off = 1'b0;
    spurious_ack();
`endif

    repeat (4) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
